// File: rtl/hdc_similarity_seq.sv
// rtl/hdc_similarity_seq.sv - sequential chunked Hamming-distance search over NUM_CLASSES class hypervectors
module hdc_similarity_seq #(
    parameter int DIMENSIONS  = 10000,
    parameter int NUM_CLASSES = 2,
    parameter int CHUNK_WIDTH = 500,
    parameter int NUM_CHUNKS  = (DIMENSIONS + CHUNK_WIDTH - 1) / CHUNK_WIDTH,
    parameter int DIST_WIDTH  = $clog2(DIMENSIONS + 1),
    parameter int LABEL_WIDTH = (NUM_CLASSES > 2) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [DIMENSIONS-1:0]             hv,
    input  logic [NUM_CLASSES*DIMENSIONS-1:0] class_hvs,
    output logic                              busy,
    output logic                              done,
    output logic [LABEL_WIDTH-1:0]            label_out,
    output logic [DIST_WIDTH-1:0]             min_dist,
    output logic [NUM_CLASSES*DIST_WIDTH-1:0] dist_flat
);

    localparam int PAD_WIDTH = NUM_CHUNKS * CHUNK_WIDTH;
    localparam int CNT_WIDTH = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t                            state_q, state_d;
    logic [CNT_WIDTH-1:0]              chunk_q, chunk_d;
    logic [LABEL_WIDTH-1:0]            cls_q, cls_d;
    logic [DIST_WIDTH-1:0]             acc_q [NUM_CLASSES];
    logic [DIST_WIDTH-1:0]             acc_d [NUM_CLASSES];
    logic [DIST_WIDTH-1:0]             best_q, best_d;
    logic [LABEL_WIDTH-1:0]            best_idx_q, best_idx_d;
    logic                              busy_q, busy_d;
    logic                              done_q, done_d;
    logic [LABEL_WIDTH-1:0]            label_q, label_d;
    logic [DIST_WIDTH-1:0]             min_q, min_d;
    logic [NUM_CLASSES*DIST_WIDTH-1:0] dist_q, dist_d;

    function automatic logic [DIST_WIDTH-1:0] popcount(input logic [CHUNK_WIDTH-1:0] x);
        logic [DIST_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < CHUNK_WIDTH; i++) begin
            n = n + DIST_WIDTH'(x[i]);
        end
        return n;
    endfunction

    // Zero padding up to a whole number of chunks makes the bits past DIMENSIONS
    // identical on both sides, so they never contribute to the distance.
    logic [PAD_WIDTH-1:0]  hv_pad;
    logic [PAD_WIDTH-1:0]  cls_pad   [NUM_CLASSES];
    logic [DIST_WIDTH-1:0] chunk_cnt [NUM_CLASSES];
    logic [31:0]           chunk_base;

    always_comb begin
        chunk_base = 32'(chunk_q) * 32'(CHUNK_WIDTH);
        hv_pad = '0;
        hv_pad[DIMENSIONS-1:0] = hv;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            cls_pad[k] = '0;
            cls_pad[k][DIMENSIONS-1:0] = class_hvs[k*DIMENSIONS +: DIMENSIONS];
            chunk_cnt[k] = popcount(hv_pad[chunk_base +: CHUNK_WIDTH]
                                    ^ cls_pad[k][chunk_base +: CHUNK_WIDTH]);
        end
    end

    // Running minimum; "<=" lets a later class take over on a tie.
    logic [DIST_WIDTH-1:0]  cur_dist;
    logic                   take_cur;
    logic [DIST_WIDTH-1:0]  cand_best;
    logic [LABEL_WIDTH-1:0] cand_idx;

    always_comb begin
        cur_dist  = acc_q[cls_q];
        take_cur  = (cls_q == '0) || (cur_dist <= best_q);
        cand_best = take_cur ? cur_dist : best_q;
        cand_idx  = take_cur ? cls_q : best_idx_q;
    end

    always_comb begin
        state_d    = state_q;
        chunk_d    = chunk_q;
        cls_d      = cls_q;
        acc_d      = acc_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        label_d    = label_q;
        min_d      = min_q;
        dist_d     = dist_q;
        done_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACCUM;
                    chunk_d = '0;
                    for (int k = 0; k < NUM_CLASSES; k++) begin
                        acc_d[k] = '0;
                    end
                end
            end
            S_ACCUM: begin
                for (int k = 0; k < NUM_CLASSES; k++) begin
                    acc_d[k] = acc_q[k] + chunk_cnt[k];
                end
                if (chunk_q == CNT_WIDTH'(NUM_CHUNKS - 1)) begin
                    state_d = S_COMPARE;
                    cls_d   = '0;
                end else begin
                    chunk_d = chunk_q + 1'b1;
                end
            end
            S_COMPARE: begin
                best_d     = cand_best;
                best_idx_d = cand_idx;
                if (cls_q == LABEL_WIDTH'(NUM_CLASSES - 1)) begin
                    // Results are registered on entry so they are valid alongside done.
                    state_d = S_DONE;
                    label_d = cand_idx;
                    min_d   = cand_best;
                    done_d  = 1'b1;
                    for (int k = 0; k < NUM_CLASSES; k++) begin
                        dist_d[k*DIST_WIDTH +: DIST_WIDTH] = acc_q[k];
                    end
                end else begin
                    cls_d = cls_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            chunk_q    <= '0;
            cls_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            label_q    <= '0;
            min_q      <= '0;
            dist_q     <= '0;
            for (int k = 0; k < NUM_CLASSES; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            chunk_q    <= chunk_d;
            cls_q      <= cls_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            label_q    <= label_d;
            min_q      <= min_d;
            dist_q     <= dist_d;
            for (int k = 0; k < NUM_CLASSES; k++) begin
                acc_q[k] <= acc_d[k];
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign label_out = label_q;
    assign min_dist  = min_q;
    assign dist_flat = dist_q;

endmodule

// File: tb/tb_hdc_similarity_seq.sv
// tb/tb_hdc_similarity_seq.sv - scoreboard bench for hdc_similarity_seq (16/3/5 and legacy 10000/2/500)
module tb_hdc_similarity_seq;

    localparam int D1 = 16, C1 = 3, DW1 = 5, LW1 = 2, LAT1 = 4 + 3 + 1;
    localparam int D2 = 10000, C2 = 2, DW2 = 14, LW2 = 1, LAT2 = 20 + 2 + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic                start1 = 1'b0, busy1, done1;
    logic [D1-1:0]       hv1 = '0;
    logic [C1*D1-1:0]    cls1 = '0;
    logic [LW1-1:0]      label1;
    logic [DW1-1:0]      min1;
    logic [C1*DW1-1:0]   dist1;

    logic                start2 = 1'b0, busy2, done2;
    logic [D2-1:0]       hv2 = '0;
    logic [C2*D2-1:0]    cls2 = '0;
    logic [LW2-1:0]      label2;
    logic [DW2-1:0]      min2;
    logic [C2*DW2-1:0]   dist2;

    hdc_similarity_seq #(.DIMENSIONS(D1), .NUM_CLASSES(C1), .CHUNK_WIDTH(5)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .hv(hv1), .class_hvs(cls1),
        .busy(busy1), .done(done1), .label_out(label1), .min_dist(min1), .dist_flat(dist1)
    );

    hdc_similarity_seq dut2 (
        .clk(clk), .rst(rst), .start(start2), .hv(hv2), .class_hvs(cls2),
        .busy(busy2), .done(done2), .label_out(label2), .min_dist(min2), .dist_flat(dist2)
    );

    typedef struct {
        int                label;
        int                mind;
        logic [C1*DW1-1:0] dists;
        int                due;
    } exp1_t;

    typedef struct {
        int                label;
        int                mind;
        logic [C2*DW2-1:0] dists;
        int                due;
    } exp2_t;

    exp1_t q1[$];
    exp2_t q2[$];
    exp1_t e1;
    exp2_t e2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, cyc);
        end
    endtask

    // Nearest class = smallest distance; among equals the highest index wins.
    function automatic exp1_t model1(input logic [D1-1:0] h, input logic [C1*D1-1:0] c, input int due);
        exp1_t r;
        int    d[C1];
        int    m;
        m = D1 + 1;
        r.dists = '0;
        for (int k = 0; k < C1; k++) begin
            d[k] = $countones(h ^ c[k*D1 +: D1]);
            if (d[k] < m) m = d[k];
            r.dists[k*DW1 +: DW1] = DW1'(d[k]);
        end
        r.label = 0;
        for (int k = 0; k < C1; k++) if (d[k] == m) r.label = k;
        r.mind = m;
        r.due  = due;
        return r;
    endfunction

    // Legacy comparator rule: label 0 only when dist0 < dist1.
    function automatic exp2_t model2(input logic [D2-1:0] h, input logic [C2*D2-1:0] c, input int due);
        exp2_t r;
        int    d0, d1;
        d0 = $countones(h ^ c[0 +: D2]);
        d1 = $countones(h ^ c[D2 +: D2]);
        r.label = (d0 < d1) ? 0 : 1;
        r.mind  = (d0 < d1) ? d0 : d1;
        r.dists = {DW2'(d1), DW2'(d0)};
        r.due   = due;
        return r;
    endfunction

    function automatic logic [D2-1:0] rand_hv();
        logic [313*32-1:0] t;
        for (int i = 0; i < 313; i++) t[i*32 +: 32] = $urandom();
        return t[D2-1:0];
    endfunction

    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                check("unexpected_done1", done1, 0);
            end else begin
                e1 = q1.pop_front();
                check("done_cycle1", cyc, e1.due);
                check("label1", label1, e1.label);
                check("min_dist1", min1, e1.mind);
                check("dist_flat1", dist1, e1.dists);
            end
        end
    end

    always @(negedge clk) begin
        if (done2 === 1'b1) begin
            if (q2.size() == 0) begin
                check("unexpected_done2", done2, 0);
            end else begin
                e2 = q2.pop_front();
                check("done_cycle2", cyc, e2.due);
                check("label2", label2, e2.label);
                check("min_dist2", min2, e2.mind);
                check("dist_flat2", dist2, e2.dists);
            end
        end
    end

    task automatic wait_idle1();
        int n = 0;
        while ((q1.size() != 0 || busy1) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle1_timeout", (q1.size() != 0 || busy1), 0);
    endtask

    task automatic wait_idle2();
        int n = 0;
        while ((q2.size() != 0 || busy2) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle2_timeout", (q2.size() != 0 || busy2), 0);
    endtask

    task automatic issue1(input logic [D1-1:0] h, input logic [C1*D1-1:0] c);
        @(posedge clk); #1;
        hv1 = h;
        cls1 = c;
        start1 = 1'b1;
        q1.push_back(model1(h, c, cyc + LAT1));
        @(posedge clk); #1;
        start1 = 1'b0;
        wait_idle1();
    endtask

    task automatic issue2(input logic [D2-1:0] h, input logic [C2*D2-1:0] c);
        @(posedge clk); #1;
        hv2 = h;
        cls2 = c;
        start2 = 1'b1;
        q2.push_back(model2(h, c, cyc + LAT2));
        @(posedge clk); #1;
        start2 = 1'b0;
        wait_idle2();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        logic [D1-1:0]    rh;
        logic [C1*D1-1:0] rc;
        logic [D2-1:0]    h2, a2, b2;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_busy1", busy1, 0);
        check("reset_done1", done1, 0);
        check("reset_label1", label1, 0);
        check("reset_min1", min1, 0);
        check("reset_dist1", dist1, 0);
        check("reset_busy2", busy2, 0);
        check("reset_dist2", dist2, 0);

        issue1(16'hA5A5, {16'hFFFF, 16'hA5A5, 16'h0000});
        issue1(16'h0000, {16'h7000, 16'h00FF, 16'h0007});
        issue1(16'hFFFF, {16'h0000, 16'h0000, 16'h0000});
        issue1(16'h8000, {16'h0000, 16'h8000, 16'h8001});

        // Back-to-back with start held: a new request is taken every 9 cycles.
        @(posedge clk); #1;
        t0 = cyc;
        hv1 = 16'hA5A5;
        cls1 = {16'hFFFF, 16'hA5A5, 16'h0000};
        start1 = 1'b1;
        for (int i = 0; i * 9 < 30; i++) q1.push_back(model1(hv1, cls1, t0 + 9 * i + LAT1));
        for (int t = 0; t < 30; t++) begin
            check("b2b_busy", busy1, (t % 9) != 0);
            @(posedge clk); #1;
        end
        start1 = 1'b0;
        wait_idle1();

        // Reset during the second ACCUM cycle discards the request.
        @(posedge clk); #1;
        hv1 = 16'hA5A5;
        cls1 = {16'hFFFF, 16'hA5A5, 16'h0000};
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", busy1, 0);
        check("midrst_done", done1, 0);
        check("midrst_label", label1, 0);
        check("midrst_min", min1, 0);
        check("midrst_dist", dist1, 0);
        issue1(16'h0000, {16'h7000, 16'h00FF, 16'h0007});

        for (int i = 0; i < 40; i++) begin
            rh = 16'($urandom());
            rc = 48'({$urandom(), $urandom()});
            if (i % 4 == 0) rc[2*D1 +: D1] = rc[0 +: D1];
            issue1(rh, rc);
        end

        for (int i = 0; i < 1000; i++) begin
            h2 = rand_hv();
            a2 = rand_hv();
            b2 = (i % 10 == 0) ? a2 : rand_hv();
            issue2(h2, {b2, a2});
        end

        check("q1_drained", q1.size(), 0);
        check("q2_drained", q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
